popcount_ternary_acc: RTL and testbench

POPCOUNT_TERNARY_ACC -- requirements
Module: popcount_ternary_acc

---
 rtl/popcount_ternary_acc.sv | 130 +++++++++++++
 tb/tb_popcount_ternary_acc.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/popcount_ternary_acc.sv
// popcount_ternary_acc
//   Accumulates signed per-beat deltas (pos_cnt - neg_cnt) from a pair of
//   popcount stages over one neuron evaluation. The running sum saturates
//   instead of wrapping. On the final beat the block registers the saturated
//   sum, a sticky saturation flag and a ternary activation, and holds them
//   until the consumer takes the result.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input beat handshake
//   pos_cnt, neg_cnt    : unsigned popcounts, CNT_W bits each
//   in_last             : final beat of the evaluation
//   out_valid/out_ready : result handshake
//   out_act             : 2'b01 = +1, 2'b00 = 0, 2'b11 = -1
//   out_sum             : signed saturated sum, ACC_W bits
//   out_sat             : clamping occurred during the evaluation
module popcount_ternary_acc #(
    parameter int CNT_W  = 4,
    parameter int ACC_W  = 8,
    parameter int THR_HI = 3,
    parameter int THR_LO = -3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] pos_cnt,
    input  logic [CNT_W-1:0] neg_cnt,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_act,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sat
);

    typedef enum logic {ACC, DONE} state_t;

    // Clamp limits expressed one bit wider than the accumulator so the
    // unclamped sum can be compared against them directly.
    localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic                    sat;
    logic                    beat;
    logic signed [CNT_W:0]   delta;
    logic signed [ACC_W:0]   sum_wide;
    logic signed [ACC_W-1:0] sum_sat;
    logic                    clip;
    logic [1:0]              act;

    assign in_ready  = (state == ACC) || out_ready;
    assign out_valid = (state == DONE);
    assign beat      = in_valid && in_ready;

    assign delta    = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
    assign sum_wide = $signed({acc[ACC_W-1], acc})
                    + $signed({{(ACC_W-CNT_W){delta[CNT_W]}}, delta});

    always_comb begin
        sum_sat = sum_wide[ACC_W-1:0];
        clip    = 1'b0;
        if (sum_wide > SUM_MAX) begin
            sum_sat = SUM_MAX[ACC_W-1:0];
            clip    = 1'b1;
        end else if (sum_wide < SUM_MIN) begin
            sum_sat = SUM_MIN[ACC_W-1:0];
            clip    = 1'b1;
        end
    end

    always_comb begin
        act = 2'b00;
        if (int'(sum_sat) > THR_HI)
            act = 2'b01;
        else if (int'(sum_sat) < THR_LO)
            act = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ACC;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC: begin
                if (beat && in_last)
                    state_nxt = DONE;
            end
            DONE: begin
                // A consumed result with a simultaneous last beat stays in
                // DONE carrying the new single-beat result.
                if (out_ready)
                    state_nxt = (beat && in_last) ? DONE : ACC;
            end
            default: state_nxt = ACC;
        endcase
    end

    // The accumulator is zeroed as soon as a last beat is taken, so while in
    // DONE it already holds 0 and a beat arriving with the consume starts a
    // fresh evaluation without extra muxing.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            sat     <= 1'b0;
            out_sum <= '0;
            out_sat <= 1'b0;
            out_act <= 2'b00;
        end else if (beat) begin
            if (in_last) begin
                acc     <= '0;
                sat     <= 1'b0;
                out_sum <= sum_sat;
                out_sat <= sat | clip;
                out_act <= act;
            end else begin
                acc <= sum_sat;
                sat <= sat | clip;
            end
        end
    end

endmodule

// File: tb/tb_popcount_ternary_acc.sv
// Directed bench for popcount_ternary_acc (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_popcount_ternary_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] pos_cnt;
    logic [3:0] neg_cnt;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_act;
    logic [7:0] out_sum;
    logic       out_sat;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    popcount_ternary_acc #(
        .CNT_W (4),
        .ACC_W (8),
        .THR_HI(3),
        .THR_LO(-3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pos_cnt  (pos_cnt),
        .neg_cnt  (neg_cnt),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_act  (out_act),
        .out_sum  (out_sum),
        .out_sat  (out_sat)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one edge; caller guarantees in_ready.
    task automatic beat(input logic [3:0] p, input logic [3:0] n, input logic l);
        in_valid = 1'b1;
        pos_cnt  = p;
        neg_cnt  = n;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [7:0] sum,
                           input logic [1:0] act, input logic sat);
        chk({tag, ".valid"}, {7'd0, out_valid}, 8'd1);
        chk({tag, ".sum"},   out_sum,           sum);
        chk({tag, ".act"},   {6'd0, out_act},   {6'd0, act});
        chk({tag, ".sat"},   {7'd0, out_sat},   {7'd0, sat});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        pos_cnt   = '0;
        neg_cnt   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst.valid", {7'd0, out_valid}, 8'd0);
        chk("rst.sum",   out_sum,           8'd0);
        chk("rst.act",   {6'd0, out_act},   8'd0);
        chk("rst.sat",   {7'd0, out_sat},   8'd0);
        chk("rst.ready", {7'd0, in_ready},  8'd1);

        // Single beat, 1-cycle latency
        beat(4'd8, 4'd2, 1'b1);
        chk_res("single", 8'd6, 2'b01, 1'b0);
        tick();
        chk("single.consumed", {7'd0, out_valid}, 8'd0);

        // Multi-beat and lower threshold boundary, back-to-back with consume
        beat(4'd2, 4'd5, 1'b0);
        chk("mid.novalid", {7'd0, out_valid}, 8'd0);
        beat(4'd1, 4'd1, 1'b0);
        beat(4'd3, 4'd2, 1'b1);
        chk_res("neg2", 8'hFE, 2'b00, 1'b0);
        beat(4'd0, 4'd3, 1'b1);
        chk_res("neg3", 8'hFD, 2'b00, 1'b0);
        beat(4'd0, 4'd4, 1'b1);
        chk_res("neg4", 8'hFC, 2'b11, 1'b0);
        tick();

        // Upper threshold boundary and equal counts
        beat(4'd3, 4'd0, 1'b1);
        chk_res("pos3", 8'd3, 2'b00, 1'b0);
        beat(4'd4, 4'd0, 1'b1);
        chk_res("pos4", 8'd4, 2'b01, 1'b0);
        beat(4'd4, 4'd4, 1'b1);
        chk_res("zero", 8'd0, 2'b00, 1'b0);
        tick();

        // Positive saturation, then sat clears for the next evaluation
        for (int i = 0; i < 10; i++) beat(4'd15, 4'd0, (i == 9));
        chk_res("satpos", 8'd127, 2'b01, 1'b1);
        beat(4'd1, 4'd0, 1'b1);
        chk_res("aftersat", 8'd1, 2'b00, 1'b0);
        tick();

        // Negative saturation
        for (int i = 0; i < 10; i++) beat(4'd0, 4'd15, (i == 9));
        chk_res("satneg", 8'h80, 2'b11, 1'b1);
        tick();

        // Backpressure: result held, in_ready low, pending beat not taken
        out_ready = 1'b0;
        beat(4'd6, 4'd0, 1'b1);
        in_valid = 1'b1;
        pos_cnt  = 4'd5;
        neg_cnt  = 4'd0;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("hold.ready", {7'd0, in_ready}, 8'd0);
            chk_res("hold", 8'd6, 2'b01, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_res("release", 8'd5, 2'b01, 1'b0);
        tick();
        chk("release.consumed", {7'd0, out_valid}, 8'd0);

        // Reset mid-evaluation discards it and overrides a pending beat
        beat(4'd7, 4'd0, 1'b0);
        beat(4'd7, 4'd0, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        pos_cnt  = 4'd9;
        in_last  = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("midrst.valid", {7'd0, out_valid}, 8'd0);
        chk("midrst.sum",   out_sum,           8'd0);
        chk("midrst.act",   {6'd0, out_act},   8'd0);
        chk("midrst.sat",   {7'd0, out_sat},   8'd0);
        beat(4'd1, 4'd0, 1'b1);
        chk_res("postrst", 8'd1, 2'b00, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
